// File: rtl/traffic_sensor_conditioner_pkg.sv
// Shared encodings for the traffic sensor conditioner and the downstream light controller.
package traffic_sensor_conditioner_pkg;

    typedef enum logic [1:0] {
        ChIdle    = 2'b00,
        ChPresent = 2'b01,
        ChHold    = 2'b10
    } ch_state_e;

    typedef enum logic {
        PrNormal = 1'b0,
        PrParade = 1'b1
    } parade_state_e;

    typedef enum logic [1:0] {
        LightGreen  = 2'b00,
        LightRed    = 2'b01,
        LightYellow = 2'b10
    } light_e;

endpackage

// File: rtl/sensor_channel.sv
// One raw input: 2-flop synchronizer, debounce filter and IDLE/PRESENT/HOLD presence FSM.
module sensor_channel
    import traffic_sensor_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned HOLD_CYC     = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_raw,
    output logic o_level_d
);

    localparam logic [CNT_W-1:0] DbLast   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLD_CYC);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_filt;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] r_hold_cnt;
    ch_state_e        r_state;

    logic             w_diff;
    logic             w_flip;
    logic             w_rise;
    logic             w_fall;
    logic             w_filt_d;
    logic [CNT_W-1:0] w_db_cnt_d;
    logic [CNT_W-1:0] w_hold_cnt_d;
    ch_state_e        w_state_d;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // The flip is used combinationally so the FSM moves on the same edge the filter flips.
    always_comb begin
        w_diff     = (r_sync2 != r_filt);
        w_flip     = w_diff && (r_db_cnt >= DbLast);
        w_rise     = w_flip && r_sync2;
        w_fall     = w_flip && !r_sync2;
        w_filt_d   = w_flip ? r_sync2 : r_filt;
        w_db_cnt_d = (!w_diff || w_flip) ? '0 : r_db_cnt + 1'b1;
    end

    always_comb begin
        w_state_d    = r_state;
        w_hold_cnt_d = r_hold_cnt;
        case (r_state)
            ChIdle: begin
                if (w_rise) begin
                    w_state_d = ChPresent;
                end
            end
            ChPresent: begin
                if (w_fall) begin
                    if (HOLD_CYC == 0) begin
                        w_state_d = ChIdle;
                    end else begin
                        w_state_d    = ChHold;
                        w_hold_cnt_d = HoldLoad;
                    end
                end
            end
            ChHold: begin
                if (w_rise) begin
                    w_state_d    = ChPresent;
                    w_hold_cnt_d = '0;
                end else if (r_hold_cnt <= 1) begin
                    w_state_d    = ChIdle;
                    w_hold_cnt_d = '0;
                end else begin
                    w_hold_cnt_d = r_hold_cnt - 1'b1;
                end
            end
            default: begin
                w_state_d    = ChIdle;
                w_hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_filt     <= 1'b0;
            r_db_cnt   <= '0;
            r_hold_cnt <= '0;
            r_state    <= ChIdle;
        end else begin
            r_filt     <= w_filt_d;
            r_db_cnt   <= w_db_cnt_d;
            r_hold_cnt <= w_hold_cnt_d;
            r_state    <= w_state_d;
        end
    end

    assign o_level_d = (w_state_d != ChIdle);

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions raw loop detectors and parade buttons into clean levels and one-cycle pulses.
module traffic_sensor_conditioner
    import traffic_sensor_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned HOLD_CYC     = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_det_a,
    input  logic i_det_b,
    input  logic i_btn_parade,
    input  logic i_btn_release,
    output logic o_TA,
    output logic o_TB,
    output logic o_P,
    output logic o_R,
    output logic o_parade_active
);

    logic          w_ta_d;
    logic          w_tb_d;
    logic          w_btn_p_d;
    logic          w_btn_r_d;
    logic          w_p_rise;
    logic          w_r_rise;
    logic          w_p_d;
    logic          w_r_d;
    parade_state_e w_pstate_d;

    logic          r_ta;
    logic          r_tb;
    logic          r_btn_p;
    logic          r_btn_r;
    logic          r_p;
    logic          r_r;
    parade_state_e r_pstate;

    sensor_channel #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .HOLD_CYC     (HOLD_CYC),
        .CNT_W        (CNT_W)
    ) u_chan_a (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_raw     (i_det_a),
        .o_level_d (w_ta_d)
    );

    sensor_channel #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .HOLD_CYC     (HOLD_CYC),
        .CNT_W        (CNT_W)
    ) u_chan_b (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_raw     (i_det_b),
        .o_level_d (w_tb_d)
    );

    sensor_channel #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .HOLD_CYC     (0),
        .CNT_W        (CNT_W)
    ) u_chan_parade (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_raw     (i_btn_parade),
        .o_level_d (w_btn_p_d)
    );

    sensor_channel #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .HOLD_CYC     (0),
        .CNT_W        (CNT_W)
    ) u_chan_release (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_raw     (i_btn_release),
        .o_level_d (w_btn_r_d)
    );

    // Rise is taken on the debounced next-state so the pulse lands on the debounce edge.
    assign w_p_rise = w_btn_p_d && !r_btn_p;
    assign w_r_rise = w_btn_r_d && !r_btn_r;

    always_comb begin
        w_pstate_d = r_pstate;
        w_p_d      = 1'b0;
        w_r_d      = 1'b0;
        case (r_pstate)
            PrNormal: begin
                if (w_p_rise) begin
                    w_pstate_d = PrParade;
                    w_p_d      = 1'b1;
                end
            end
            PrParade: begin
                if (w_r_rise) begin
                    w_pstate_d = PrNormal;
                    w_r_d      = 1'b1;
                end
            end
            default: begin
                w_pstate_d = PrNormal;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_ta     <= 1'b0;
            r_tb     <= 1'b0;
            r_btn_p  <= 1'b0;
            r_btn_r  <= 1'b0;
            r_p      <= 1'b0;
            r_r      <= 1'b0;
            r_pstate <= PrNormal;
        end else begin
            r_ta     <= w_ta_d;
            r_tb     <= w_tb_d;
            r_btn_p  <= w_btn_p_d;
            r_btn_r  <= w_btn_r_d;
            r_p      <= w_p_d;
            r_r      <= w_r_d;
            r_pstate <= w_pstate_d;
        end
    end

    assign o_TA            = r_ta;
    assign o_TB            = r_tb;
    assign o_P             = r_p;
    assign o_R             = r_r;
    assign o_parade_active = (r_pstate == PrParade);

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner with default parameters (debounce 4, hold 8).
module tb_traffic_sensor_conditioner;

    logic clk = 1'b0;
    logic rstn;
    logic det_a, det_b, btn_p, btn_r;
    logic o_ta, o_tb, o_p, o_r, o_act;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    traffic_sensor_conditioner dut (
        .i_clk           (clk),
        .i_rstn          (rstn),
        .i_det_a         (det_a),
        .i_det_b         (det_b),
        .i_btn_parade    (btn_p),
        .i_btn_release   (btn_r),
        .o_TA            (o_ta),
        .o_TB            (o_tb),
        .o_P             (o_p),
        .o_R             (o_r),
        .o_parade_active (o_act)
    );

    // Inputs {a,b,p,r}, edges to wait, expected {TA,TB,P,R,active}.
    typedef struct {
        logic [3:0] in;
        int         n;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] in, input int n, input logic [4:0] exp);
        vec_t v;
        v.in  = in;
        v.n   = n;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [4:0] want);
        logic [4:0] got;
        got = {o_ta, o_tb, o_p, o_r, o_act};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: {TA,TB,P,R,act} got %b want %b at %0t", nm, got, want, $time);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] in);
        {det_a, det_b, btn_p, btn_r} = in;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        drive(4'b0000);
        edges(3);
        check("reset", 5'b00000);
        rstn = 1'b1;
        edges(3);
        check("post_reset_idle", 5'b00000);

        // det A rise/fall, then parade button scenarios
        add(4'b1000, 5,  5'b00000);
        add(4'b1000, 1,  5'b10000);
        add(4'b0000, 13, 5'b10000);
        add(4'b0000, 1,  5'b00000);
        add(4'b0010, 5,  5'b00000);
        add(4'b0010, 1,  5'b00101);
        add(4'b0010, 1,  5'b00001);
        add(4'b0010, 3,  5'b00001);
        add(4'b0000, 6,  5'b00001);
        add(4'b0010, 6,  5'b00001);
        add(4'b0010, 4,  5'b00001);
        add(4'b0000, 6,  5'b00001);
        add(4'b0001, 6,  5'b00010);
        add(4'b0001, 1,  5'b00000);
        add(4'b0000, 6,  5'b00000);
        add(4'b0011, 5,  5'b00000);
        add(4'b0011, 1,  5'b00101);
        add(4'b0011, 1,  5'b00001);
        add(4'b0000, 6,  5'b00001);
        add(4'b0011, 6,  5'b00010);
        add(4'b0011, 1,  5'b00000);
        add(4'b0000, 6,  5'b00000);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].in);
            edges(vecs[i].n);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // 3-cycle glitches on det A never reach the output
        for (int k = 0; k < 4; k++) begin
            det_a = 1'b1;
            for (int c = 0; c < 3; c++) begin
                edges(1);
                check("glitch_hi", 5'b00000);
            end
            det_a = 1'b0;
            for (int c = 0; c < 3; c++) begin
                edges(1);
                check("glitch_lo", 5'b00000);
            end
        end
        edges(10);
        check("glitch_settle", 5'b00000);

        // det B re-rises during HOLD: TB must never drop
        det_b = 1'b1;
        edges(6);
        check("tb_rise", 5'b01000);
        det_b = 1'b0;
        edges(6);
        check("tb_hold_enter", 5'b01000);
        edges(1);
        det_b = 1'b1;
        for (int c = 0; c < 20; c++) begin
            edges(1);
            check("tb_no_gap", 5'b01000);
        end

        // reset mid-HOLD on A and mid-PARADE
        det_a = 1'b1;
        btn_p = 1'b1;
        edges(6);
        check("pre_rst_rise", 5'b11101);
        det_a = 1'b0;
        edges(8);
        check("pre_rst_hold", 5'b11001);
        rstn = 1'b0;
        #1;
        check("async_reset", 5'b00000);
        det_a = 1'b1;
        det_b = 1'b0;
        btn_p = 1'b0;
        edges(2);
        check("in_reset", 5'b00000);
        rstn = 1'b1;
        edges(5);
        check("post_rst_e5", 5'b00000);
        edges(1);
        check("post_rst_e6", 5'b10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
